// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: write-mode encodings, address constants and the per-bit mode function
package reg_bank_pkg;
    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SET  = 2'b01;
    localparam logic [1:0] MODE_CLR  = 2'b10;
    localparam logic [1:0] MODE_TOG  = 2'b11;
    localparam int ADDR_NONE = 0;

    function automatic logic next_bit(input logic [1:0] mode, input logic r, input logic d);
        return (mode == MODE_LOAD) ? d :
               (mode == MODE_SET)  ? (r | d) :
               (mode == MODE_CLR)  ? (r & ~d) : (r ^ d);
    endfunction
endpackage

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one register with its one-way lock bit and write-mode update
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              lock_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] r_o,
    output logic              locked_o,
    output logic              blocked_o
);
    logic [DATA_W-1:0] r_q, r_d;
    logic              lock_q, lock_d;

    assign lock_d    = lock_q | lock_i;
    assign blocked_o = we_i & lock_q;
    assign r_o       = r_q;
    assign locked_o  = lock_q;

    // next value: mode function applied per bit, suppressed while locked
    always_comb begin
        r_d = r_q;
        for (int b = 0; b < DATA_W; b++)
            r_d[b] = (we_i && !lock_q) ? next_bit(mode_i, r_q[b], d_i[b]) : r_q[b];
    end

    // register and lock state; lock only clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RST_VAL;
            lock_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            lock_q <= lock_d;
        end
    end
endmodule

// File: rtl/reg_bank_sel.sv
// reg_bank_sel: address-selected register bank with write modes, locks, readback and sticky error
module reg_bank_sel
    import reg_bank_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 3,
    parameter int                ADDR_W   = $clog2(NUM_REGS + 1),
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          d,
    input  logic                       lock_en,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [NUM_REGS*DATA_W-1:0] q,
    output logic [NUM_REGS-1:0]        locked,
    output logic                       err,
    input  logic                       err_clr
);
    localparam logic [ADDR_W-1:0] A_NONE = ADDR_W'(ADDR_NONE);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] sel, rsel, blocked;
    logic [DATA_W-1:0]   rd_val, rd_data_q, rd_data_d;
    logic                rd_valid_q, err_q, err_d, err_set;

    // one-hot decode of write and read addresses; out-of-range decodes to no hit
    always_comb begin
        sel    = '0;
        rsel   = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i]  = addr == ADDR_W'(i + 1);
            rsel[i] = rd_addr == ADDR_W'(i + 1);
            if (rsel[i]) rd_val = regs[i];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_bank_cell #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_cell (
            .clk      (clk),
            .rst      (rst),
            .we_i     (wr_en & sel[i]),
            .lock_i   (lock_en & sel[i]),
            .mode_i   (mode),
            .d_i      (d),
            .r_o      (regs[i]),
            .locked_o (locked[i]),
            .blocked_o(blocked[i])
        );
        assign q[i*DATA_W +: DATA_W] = regs[i];
    end

    // error sources: bad write address, write to locked register, bad read address; set beats clear
    always_comb begin
        err_set   = (wr_en && addr != A_NONE && !(|sel)) || (|blocked) || (rd_en && !(|rsel));
        err_d     = err_set | (err_q & ~err_clr);
        rd_data_d = rd_en ? rd_val : rd_data_q;
    end

    // readback and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            err_q      <= err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
endmodule

// File: doc/reg_bank_sel.md
# reg_bank_sel

Parametrised successor to the three-register, address-selected register bunch: NUM_REGS registers of DATA_W bits, each written through one shared data/address port. It adds write modes (load/set/clear/toggle), per-register write lock, a registered readback port and a sticky address-error flag. It sits between a simple control master and the datapath, which consumes the flat parallel output bus.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 3, number of registers (1..15)
- ADDR_W, $clog2(NUM_REGS+1), address width; address 0 is reserved as "no select"
- RST_VAL, 0, reset value of every register (DATA_W bits)

- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- wr_en  in  1  write strobe, sampled each rising edge
- addr  in  ADDR_W  write select: value k in 1..NUM_REGS targets register k-1; 0 means no write
- mode  in  2  write mode: 00 LOAD, 01 SET (OR), 10 CLR (AND NOT), 11 TOG (XOR)
- d  in  DATA_W  write data / bit mask
- lock_en  in  1  lock request for the register selected by addr
- rd_en  in  1  readback request
- rd_addr  in  ADDR_W  readback select, same encoding as addr
- rd_data  out  DATA_W  readback data
- rd_valid  out  1  rd_data is valid this cycle
- q  out  NUM_REGS*DATA_W  flat register contents; register i is at bits [i*DATA_W +: DATA_W]
- locked  out  NUM_REGS  per-register lock status
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- Write happens on a rising edge with wr_en=1, addr in 1..NUM_REGS and the target not locked. The new value is:
  - LOAD: d
  - SET: r|d
  - CLR: r&~d
  - TOG: r^d
- wr_en=1 with addr=0 is a no-op. It does not raise err.
- wr_en=1 with addr>NUM_REGS sets err. No register changes.
- wr_en=1 to a locked register sets err. The register keeps its value.
- lock_en=1 with a valid addr sets locked[addr-1] on that edge. The lock holds until rst; there is no unlock.
  - lock_en is independent of wr_en.
  - lock_en with addr=0 or addr>NUM_REGS is ignored and does not raise err.
- Write and lock on the same edge, same register, unlocked: the write takes effect and the lock applies from the next edge.
- Readback: rd_en=1 captures the selected register into rd_data and sets rd_valid=1 on the next edge.
  - rd_en=0 gives rd_valid=0 the next cycle; rd_data holds its last value.
  - rd_addr=0 or rd_addr>NUM_REGS gives rd_data=0, rd_valid=1 and sets err.
- Read and write to the same register on the same edge: rd_data returns the pre-write value (read-before-write).
- err: err_clr=1 clears it. If a new error condition occurs on the same edge as err_clr, set wins and err stays 1.

## Timing
- Reset values: all registers = RST_VAL, locked=0, rd_data=0, rd_valid=0, err=0.
- rst overrides wr_en, lock_en, rd_en and err_clr on the same edge. Reset mid-stream discards the in-flight readback; rd_valid=0 on the next cycle.
- Write latency is 1 clock: q updates on the edge that samples wr_en.
- Read latency is 1 clock: rd_data/rd_valid are registered, and back-to-back reads give one result per cycle.
- err and locked are registered and update on the same edge as the causing event.
- No combinational path from any input to any output.

## Structure
- Package reg_bank_pkg holds:
  - mode encodings MODE_LOAD=2'b00, MODE_SET=2'b01, MODE_CLR=2'b10, MODE_TOG=2'b11
  - ADDR_NONE=0
  - a function computing the next value from (mode, r, d)
- Sub-module reg_bank_cell, instantiated NUM_REGS times in a generate loop. One cell holds one register plus its lock bit and applies the mode function.
- The top level holds:
  - address decode
  - error detection
  - the readback mux/register
  - the err register

## Test plan
Defaults DATA_W=8, NUM_REGS=3.
1. Reset, then write 8'hFF to addr 1, then 8'hAA to addr 2 -> q = {8'h00, 8'hAA, 8'hFF}, err=0.
2. Reg0=8'hF0; apply SET d=8'h0F, then CLR d=8'h3C, then TOG d=8'hFF -> reg0 = 8'hFF, then 8'hC3, then 8'h3C.
3. Lock addr 3 together with LOAD 8'h55, then LOAD 8'h99 to addr 3 -> reg2=8'h55, locked=3'b100, err=1. Then err_clr -> err=0.
4. Write addr=3'd0... rather addr=2'd0 with wr_en -> no change, err=0. Write addr=2'd3 with NUM_REGS=2 (second build) -> err=1, q unchanged.
5. Reg1=8'h11; same edge: LOAD 8'h22 to addr 2 and rd_en with rd_addr=2 -> next cycle rd_data=8'h11, rd_valid=1. Following read -> 8'h22.
6. Assert rst while rd_en=1 and err=1 -> next cycle all q=0, locked=0, rd_valid=0, err=0. Repeat with RST_VAL=8'hA5 -> all registers 8'hA5.
